// File: rtl/rr_mux3_arbiter.sv
// ============================================================================
//  Module      : rr_mux3_arbiter
//  Description : Round-robin arbiter and select sequencer for a shared 3:1 mux
//                with a bounded hold time per owner under contention.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_mux3_arbiter #(
  parameter int W        = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   req,
  input  logic [W-1:0] B1,
  input  logic [W-1:0] B2,
  input  logic [W-1:0] B3,
  output logic [1:0]   C,
  output logic [2:0]   grant,
  output logic         busy,
  output logic [W-1:0] A
);

  localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_c, w_c_nxt;
  logic [2:0]  r_grant;
  logic        r_busy;
  logic [7:0]  r_hold, w_hold_nxt;
  logic [1:0]  r_last, w_last_nxt;

  logic [1:0]  w_cand1, w_cand2;
  logic [1:0]  w_pick_all, w_pick_oth;
  logic        w_own_req, w_oth_req;

  function automatic logic [1:0] f_next(input logic [1:0] code);
    return (code == 2'd3) ? 2'd1 : code + 2'd1;
  endfunction

  function automatic logic [2:0] f_onehot(input logic [1:0] code);
    case (code)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Rotation is anchored on the last owner; while granting, last equals the owner,
  // so the first two candidates are exactly the non-owners in RR order.
  always_comb begin
    w_cand1    = f_next(r_last);
    w_cand2    = f_next(w_cand1);
    w_own_req  = |(req & r_grant);
    w_oth_req  = |(req & ~r_grant);
    w_pick_oth = 2'd0;
    if (|(req & f_onehot(w_cand1)))      w_pick_oth = w_cand1;
    else if (|(req & f_onehot(w_cand2))) w_pick_oth = w_cand2;
    w_pick_all = w_pick_oth;
    if (w_pick_oth == 2'd0 && |(req & f_onehot(r_last))) w_pick_all = r_last;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    w_hold_nxt  = r_hold;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        w_c_nxt    = 2'd0;
        w_hold_nxt = 8'd0;
        if (|req) begin
          w_state_nxt = S_GRANT;
          w_c_nxt     = w_pick_all;
          w_last_nxt  = w_pick_all;
        end
      end
      S_GRANT: begin
        if (w_oth_req && (!w_own_req || r_hold == c_HOLD_LAST)) begin
          w_c_nxt    = w_pick_oth;
          w_last_nxt = w_pick_oth;
          w_hold_nxt = 8'd0;
        end else if (!w_own_req) begin
          w_state_nxt = S_IDLE;
          w_c_nxt     = 2'd0;
          w_hold_nxt  = 8'd0;
        end else if (r_hold != c_HOLD_LAST) begin
          w_hold_nxt = r_hold + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_c_nxt     = 2'd0;
        w_hold_nxt  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_c     <= 2'd0;
      r_grant <= 3'b000;
      r_busy  <= 1'b0;
      r_hold  <= 8'd0;
      r_last  <= 2'd3;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_grant <= f_onehot(w_c_nxt);
      r_busy  <= (w_state_nxt == S_GRANT);
      r_hold  <= w_hold_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    case (r_c)
      2'd1:    A = B1;
      2'd2:    A = B2;
      2'd3:    A = B3;
      default: A = '0;
    endcase
  end

  assign C     = r_c;
  assign grant = r_grant;
  assign busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux3_arbiter.sv
// ============================================================================
//  Module      : tb_rr_mux3_arbiter
//  Description : Directed and randomized checks of rr_mux3_arbiter against a
//                cycle-count reference model of the arbitration rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_mux3_arbiter;

  localparam int W        = 8;
  localparam int MAX_HOLD = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req;
  logic [W-1:0] B1, B2, B3;
  logic [1:0]   C;
  logic [2:0]   grant;
  logic         busy;
  logic [W-1:0] A;

  int n_checks = 0;
  int n_errors = 0;

  int m_owner, m_last, m_n;
  int wait_cnt [3];
  int max_wait;

  rr_mux3_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .B1(B1), .B2(B2), .B3(B3),
    .C(C), .grant(grant), .busy(busy), .A(A)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First requester found walking forward from 'last'; owner excluded on a switch.
  function automatic int rr(input int last, input logic [2:0] mask, input bit excl);
    for (int k = 1; k <= 3; k++) begin
      int cand;
      cand = ((last - 1 + k) % 3) + 1;
      if (!(excl && k == 3) && mask[cand-1]) return cand;
    end
    return 0;
  endfunction

  // m_n counts cycles the current owner has held C so far.
  task automatic model_step();
    bit own, oth;
    if (rst) begin
      m_owner = 0; m_last = 3; m_n = 0;
    end else if (m_owner == 0) begin
      m_owner = rr(m_last, req, 1'b0);
      if (m_owner != 0) begin m_last = m_owner; m_n = 1; end
    end else begin
      own = req[m_owner-1];
      oth = (req & ~(3'b001 << (m_owner - 1))) != 3'b000;
      if (oth && (!own || m_n >= MAX_HOLD)) begin
        m_owner = rr(m_owner, req, 1'b1); m_last = m_owner; m_n = 1;
      end else if (!own) begin
        m_owner = 0; m_n = 0;
      end else begin
        m_n++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] exp_a;
    logic [2:0]   exp_g;
    exp_g = (m_owner == 0) ? 3'b000 : 3'(3'b001 << (m_owner - 1));
    exp_a = (m_owner == 1) ? B1 : (m_owner == 2) ? B2 : (m_owner == 3) ? B3 : '0;
    chk({tag, ".C"},     32'(C),     32'(m_owner));
    chk({tag, ".grant"}, 32'(grant), 32'(exp_g));
    chk({tag, ".busy"},  32'(busy),  32'(m_owner != 0));
    chk({tag, ".A"},     32'(A),     32'(exp_a));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 3; i++) begin
      if (!rst && req[i] && !grant[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    req = 3'b000;
    for (int i = 0; i < cycles; i++) tick();
    rst = 1'b0;
  endtask

  int seq3 [13] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 1};
  int guard;

  initial begin
    rst = 1'b1; req = 3'b000; B1 = '0; B2 = '0; B3 = '0;
    m_owner = 0; m_last = 3; m_n = 0; max_wait = 0;
    for (int i = 0; i < 3; i++) wait_cnt[i] = 0;

    // Reset state
    do_reset(2);
    chk("rst.C", 32'(C), 32'd0);
    chk("rst.grant", 32'(grant), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.A", 32'(A), 32'd0);

    // Single uncontested requester keeps the bus
    B1 = 8'h01; B2 = 8'h22; B3 = 8'h33; req = 3'b001;
    tick();
    chk("solo.C", 32'(C), 32'd1);
    chk("solo.grant", 32'(grant), 32'b001);
    chk("solo.A", 32'(A), 32'h01);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("solo.hold", 32'(C), 32'd1);
    end

    // All requesting: MAX_HOLD rotation starting at B1
    do_reset(1);
    req = 3'b111;
    for (int i = 0; i < 13; i++) begin
      tick();
      chk("rot.C", 32'(C), 32'(seq3[i]));
      check_model("rot");
    end

    // Owner drops with another pending: direct switch, then go idle
    do_reset(1);
    req = 3'b111;
    guard = 0;
    while (C != 2'd2 && guard < 20) begin tick(); guard++; end
    chk("drop.reach2", 32'(C), 32'd2);
    req = 3'b101;
    tick();
    chk("drop.C3", 32'(C), 32'd3);
    chk("drop.busy", 32'(busy), 32'd1);
    req = 3'b000;
    tick();
    chk("drop.idleC", 32'(C), 32'd0);
    chk("drop.idlebusy", 32'(busy), 32'd0);

    // Reset mid-grant aborts, then RR resumes from last=3
    do_reset(1);
    req = 3'b100;
    tick(); tick(); tick();
    chk("midrst.C3", 32'(C), 32'd3);
    rst = 1'b1;
    tick();
    chk("midrst.C", 32'(C), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    rst = 1'b0; req = 3'b110;
    tick();
    chk("midrst.C2", 32'(C), 32'd2);
    check_model("midrst");

    // Randomized traffic against the model
    do_reset(1);
    max_wait = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 3; i++) req[i] = ($urandom_range(0, 3) != 0);
      end
      B1 = W'($urandom); B2 = W'($urandom); B3 = W'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      tick();
      check_model("rand");
      chk("rand.onehot", 32'($countones(grant) <= 1), 32'd1);
    end
    rst = 1'b0;
    chk("rand.starve", 32'(max_wait <= 2 * MAX_HOLD + 2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
